// File: rtl/cnn_input_loader.sv
// Serial pixel stream to flat feature_map packer for the layer-1 convolution stage.
// Fills a frame slot by slot, fires a one-cycle data_valid, then holds until result_valid.
module cnn_input_loader #(
  parameter int unsigned FEATURE_BITWIDTH = 8,
  parameter int unsigned INPUT_CHANNELS   = 1,
  parameter int unsigned IMAGE_WIDTH      = 28,
  parameter int unsigned IMAGE_HEIGHT     = 28
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FEATURE_BITWIDTH-1:0] in_data,
  input  logic                        in_last,
  input  logic                        result_valid,
  output logic                        data_valid,
  output logic [FEATURE_BITWIDTH*INPUT_CHANNELS*IMAGE_WIDTH*IMAGE_HEIGHT-1:0] feature_map,
  output logic                        busy,
  output logic                        frame_error
);

  localparam int unsigned N  = INPUT_CHANNELS * IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_FIRE,
    S_WAIT
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [CW-1:0]               r_cnt;
  logic [CW-1:0]               w_next_cnt;
  logic                        w_accept;
  logic                        w_at_end;
  logic                        w_error;
  logic                        r_frame_error;
  logic [FEATURE_BITWIDTH-1:0] r_slot [N];

  assign w_accept = in_valid && (r_state == S_LOAD);
  assign w_at_end = (r_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_LOAD;
      r_cnt         <= '0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_frame_error <= w_error;
    end
  end

  // A framing mismatch drops the partial frame by rewinding the counter; slots keep stale data.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_error      = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (in_last && w_at_end) begin
            w_next_state = S_FIRE;
            w_next_cnt   = '0;
          end else if (in_last || w_at_end) begin
            w_error    = 1'b1;
            w_next_cnt = '0;
          end else begin
            w_next_cnt = r_cnt + CW'(1);
          end
        end
      end
      S_FIRE: w_next_state = S_WAIT;
      S_WAIT: begin
        if (result_valid) begin
          w_next_state = S_LOAD;
          w_next_cnt   = '0;
        end
      end
      default: w_next_state = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot <= '{default: '0};
    end else if (w_accept) begin
      r_slot[r_cnt] <= in_data;
    end
  end

  // Slot k sits at bits [k*FEATURE_BITWIDTH +: FEATURE_BITWIDTH]; channel 0 lowest.
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign feature_map[g*FEATURE_BITWIDTH +: FEATURE_BITWIDTH] = r_slot[g];
  end

  assign in_ready    = (r_state == S_LOAD);
  assign data_valid  = (r_state == S_FIRE);
  assign busy        = (r_state == S_FIRE) || (r_state == S_WAIT);
  assign frame_error = r_frame_error;

endmodule

// File: tb/tb_cnn_input_loader.sv
// Bench for cnn_input_loader: a 4x4x1 and a 3x3x2 instance checked against a frame-level model.
module tb_cnn_input_loader;

  localparam int NA = 16;
  localparam int NB = 18;

  logic clk = 1'b0;
  logic reset_n;
  logic a_valid, a_last, a_rv, a_ready, a_dv, a_busy, a_err;
  logic [7:0] a_data;
  logic [NA*8-1:0] a_fm;
  logic b_valid, b_last, b_rv, b_ready, b_dv, b_busy, b_err;
  logic [7:0] b_data;
  logic [NB*8-1:0] b_fm;

  always #5 clk = ~clk;

  cnn_input_loader #(.FEATURE_BITWIDTH(8), .INPUT_CHANNELS(1), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .in_last(a_last), .result_valid(a_rv), .data_valid(a_dv), .feature_map(a_fm),
    .busy(a_busy), .frame_error(a_err));

  cnn_input_loader #(.FEATURE_BITWIDTH(8), .INPUT_CHANNELS(2), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_last(b_last), .result_valid(b_rv), .data_valid(b_dv), .feature_map(b_fm),
    .busy(b_busy), .frame_error(b_err));

  int checks = 0;
  int errors = 0;

  // Frame-level model: collected pixels, beats so far, and whether a frame is parked.
  int m_fm [2][NB];
  int m_cnt [2];
  bit m_ready [2], m_dv [2], m_err [2], m_busy [2];

  function automatic void model_reset();
    for (int id = 0; id < 2; id++) begin
      for (int k = 0; k < NB; k++) m_fm[id][k] = 0;
      m_cnt[id] = 0; m_ready[id] = 1; m_dv[id] = 0; m_err[id] = 0; m_busy[id] = 0;
    end
  endfunction

  function automatic void model_step(int id, int n, bit v, int d, bit l, bit rv);
    m_err[id] = 0;
    if (m_dv[id]) begin
      m_dv[id] = 0;
    end else if (!m_ready[id]) begin
      if (rv) begin m_ready[id] = 1; m_busy[id] = 0; m_cnt[id] = 0; end
    end else if (v) begin
      m_fm[id][m_cnt[id]] = d & 255;
      if (l && m_cnt[id] == n - 1) begin
        m_dv[id] = 1; m_ready[id] = 0; m_busy[id] = 1; m_cnt[id] = 0;
      end else if (l || m_cnt[id] == n - 1) begin
        m_err[id] = 1; m_cnt[id] = 0;
      end else begin
        m_cnt[id] = m_cnt[id] + 1;
      end
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else begin
      model_step(0, NA, a_valid, int'(a_data), a_last, a_rv);
      model_step(1, NB, b_valid, int'(b_data), b_last, b_rv);
    end
  end

  task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [159:0] exp_fm(int id, int n);
    logic [159:0] r = '0;
    int v;
    for (int k = 0; k < n; k++) begin
      v = m_fm[id][k];
      r[k*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  task automatic compare_all();
    chk("a_ready", a_ready, m_ready[0]); chk("a_dv", a_dv, m_dv[0]);
    chk("a_err", a_err, m_err[0]);      chk("a_busy", a_busy, m_busy[0]);
    chk("a_fm", a_fm, exp_fm(0, NA));
    chk("b_ready", b_ready, m_ready[1]); chk("b_dv", b_dv, m_dv[1]);
    chk("b_err", b_err, m_err[1]);      chk("b_busy", b_busy, m_busy[1]);
    chk("b_fm", b_fm, exp_fm(1, NB));
  endtask

  task automatic cyc(int id, bit v, int d, bit l, bit rv);
    a_valid = 0; a_data = 0; a_last = 0; a_rv = 0;
    b_valid = 0; b_data = 0; b_last = 0; b_rv = 0;
    if (id == 0) begin a_valid = v; a_data = d[7:0]; a_last = l; a_rv = rv; end
    else         begin b_valid = v; b_data = d[7:0]; b_last = l; b_rv = rv; end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic full_frame_a(int base);
    for (int k = 0; k < NA; k++) cyc(0, 1, base + k, k == NA - 1, 0);
    chk("frame_dv", a_dv, 1'b1);
  endtask

  typedef struct {
    bit v; int d; bit l; bit rv;
    bit e_ready; bit e_dv; bit e_err; bit e_busy;
  } vec_t;

  vec_t tbl [48];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [159:0] ramp, partial, pat;
    int n, k, dvc, cycles;
    int bd [NB];

    n = 0;
    for (int i = 0; i < 16; i++)
      tbl[n++] = '{v:1'b1, d:i, l:(i == 15), rv:1'b0,
                   e_ready:(i != 15), e_dv:(i == 15), e_err:1'b0, e_busy:(i == 15)};
    for (int i = 0; i < 20; i++)
      tbl[n++] = '{v:1'b1, d:170, l:1'b0, rv:1'b0, e_ready:1'b0, e_dv:1'b0, e_err:1'b0, e_busy:1'b1};
    tbl[n++] = '{v:1'b1, d:170, l:1'b0, rv:1'b1, e_ready:1'b1, e_dv:1'b0, e_err:1'b0, e_busy:1'b0};
    for (int i = 0; i < 10; i++)
      tbl[n++] = '{v:1'b1, d:100 + i, l:(i == 9), rv:1'b0,
                   e_ready:1'b1, e_dv:1'b0, e_err:(i == 9), e_busy:1'b0};
    tbl[n++] = '{v:1'b0, d:0, l:1'b0, rv:1'b0, e_ready:1'b1, e_dv:1'b0, e_err:1'b0, e_busy:1'b0};

    ramp = '0; partial = '0;
    for (int i = 0; i < NA; i++) begin
      ramp[i*8 +: 8] = 8'(i);
      partial[i*8 +: 8] = (i < 10) ? 8'(100 + i) : 8'(i);
    end

    reset_n = 1'b0;
    a_valid = 0; a_data = 0; a_last = 0; a_rv = 0;
    b_valid = 0; b_data = 0; b_last = 0; b_rv = 0;
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_ready", a_ready, 1'b1); chk("rst_busy", a_busy, 1'b0);
    chk("rst_fm", a_fm, '0);         chk("rst_dv", a_dv, 1'b0);
    reset_n = 1'b1;

    // Full frame, 20 stalled WAIT cycles, release, then an early-in_last frame.
    for (int i = 0; i < 48; i++) begin
      cyc(0, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rv);
      chk("tbl_ready", a_ready, tbl[i].e_ready); chk("tbl_dv", a_dv, tbl[i].e_dv);
      chk("tbl_err", a_err, tbl[i].e_err);       chk("tbl_busy", a_busy, tbl[i].e_busy);
      if (i == 15 || i == 36) chk("ramp_fm", a_fm, ramp);
    end
    chk("partial_keep", a_fm, partial);

    // Missing in_last on the final slot.
    for (int i = 0; i < NA; i++) cyc(0, 1, 200 + i, 0, 0);
    chk("nolast_err", a_err, 1'b1); chk("nolast_ready", a_ready, 1'b1); chk("nolast_busy", a_busy, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("nolast_err_clr", a_err, 1'b0);
    full_frame_a(50);
    pat = '0;
    for (int i = 0; i < NA; i++) pat[i*8 +: 8] = 8'(50 + i);
    chk("reload_fm", a_fm, pat);
    cyc(0, 0, 0, 0, 1);
    chk("rv_in_fire_ignored", a_ready, 1'b0);
    cyc(0, 0, 0, 0, 1);
    chk("rv_first_wait", a_ready, 1'b1);

    // Gappy stream into the two-channel instance.
    for (int i = 0; i < NB; i++) bd[i] = int'($urandom_range(0, 255));
    k = 0; dvc = 0; cycles = 0;
    while (k < NB && cycles < 400) begin
      if ($urandom_range(0, 1) == 1) begin cyc(1, 1, bd[k], k == NB - 1, 0); k++; end
      else cyc(1, 0, 0, 0, 0);
      cycles++;
      if (b_dv) dvc++;
    end
    chk("b_beats_sent", k, NB);
    repeat (5) begin cyc(1, 0, 0, 0, 0); if (b_dv) dvc++; end
    chk("b_dv_count", dvc, 1);
    pat = '0;
    for (int i = 0; i < NB; i++) pat[i*8 +: 8] = 8'(bd[i]);
    chk("b_order_fm", b_fm, pat);
    cyc(1, 0, 0, 0, 1);
    chk("b_release", b_ready, 1'b1);

    // Random traffic on both instances with mostly well-formed framing.
    for (int i = 0; i < 800; i++) begin
      a_valid = 1'($urandom_range(0, 1)); a_data = 8'($urandom);
      a_last = (m_cnt[0] == NA - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
      a_rv = ($urandom_range(0, 3) == 0);
      b_valid = 1'($urandom_range(0, 1)); b_data = 8'($urandom);
      b_last = (m_cnt[1] == NB - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
      b_rv = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      @(negedge clk);
      compare_all();
    end

    // Asynchronous reset mid-frame and mid-WAIT.
    #2 reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 7; i++) cyc(0, 1, 9 + i, 0, 0);
    #2 reset_n = 1'b0;
    #1 compare_all();
    chk("arst_frame_ready", a_ready, 1'b1); chk("arst_frame_fm", a_fm, '0);
    @(negedge clk) reset_n = 1'b1;
    full_frame_a(30);
    repeat (3) cyc(0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 compare_all();
    chk("arst_wait_busy", a_busy, 1'b0); chk("arst_wait_ready", a_ready, 1'b1);
    @(negedge clk) reset_n = 1'b1;
    full_frame_a(70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_input_loader.md
Name: cnn_input_loader

Overview:
- Upstream feeder for the layer-1 convolution stage.
- Accepts pixels serially over a valid/ready stream and packs them into the flat feature_map bus the convolution stage consumes.
- Issues a single-cycle data_valid pulse when a full frame is assembled.
- Holds the frame stable and back-pressures input until the convolution stage reports result_valid.

Parameters:
FEATURE_BITWIDTH, 8, bits per pixel
INPUT_CHANNELS, 1, channels per frame
IMAGE_WIDTH, 28, pixels per row
IMAGE_HEIGHT, 28, rows per channel

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  pixel beat valid
in_ready  output  1  loader can accept a beat
in_data  input  FEATURE_BITWIDTH  pixel value
in_last  input  1  marks final pixel of frame
result_valid  input  1  convolution stage finished current frame
data_valid  output  1  one-cycle pulse: feature_map holds a complete frame
feature_map  output  FEATURE_BITWIDTH*INPUT_CHANNELS*IMAGE_WIDTH*IMAGE_HEIGHT  packed frame
busy  output  1  high in FIRE or WAIT
frame_error  output  1  one-cycle pulse on framing mismatch

Behaviour:
- Interface: single clock clk; reset_n is asynchronous and active-low.
- Reset values: state=LOAD, pixel counter=0, feature_map all zero, data_valid=0, frame_error=0, busy=0, in_ready=1 (in LOAD only).
- Definitions:
  - N = INPUT_CHANNELS*IMAGE_WIDTH*IMAGE_HEIGHT.
  - Beat accepted = in_valid & in_ready on a rising clk edge.
- Packing:
  - Beat k (0-based) is written to feature_map[k*FEATURE_BITWIDTH +: FEATURE_BITWIDTH].
  - Order is channel-major, then row, then column: k = c*W*H + r*W + col.
  - Channel 0 occupies the lowest bits.
  - Slots not yet written in the current frame keep their previous contents. They are not cleared between frames.
- States:
  - LOAD: in_ready=1. Each accepted beat writes slot k and increments the counter.
    - If the beat is at k=N-1 with in_last=1: go to FIRE.
    - If in_last=1 at k<N-1, or in_last=0 at k=N-1: pulse frame_error next cycle, reset counter to 0, stay in LOAD. The partial frame is discarded and data_valid is not raised.
  - FIRE: one cycle. data_valid=1, in_ready=0. Unconditionally go to WAIT.
  - WAIT: in_ready=0, feature_map frozen. When result_valid=1: counter=0, go to LOAD next cycle (in_ready=1 the following cycle).
- Latency: final beat accepted at edge T -> data_valid high for exactly the cycle after T, then low.
- result_valid:
  - Sampled only in WAIT, including when it is asserted in the first WAIT cycle.
  - Ignored in LOAD and FIRE. It is not remembered.
- Error pulse: frame_error is registered and high for exactly one cycle. It cannot coincide with data_valid.
- Input stall: in_valid low in LOAD holds the counter; gaps are unbounded.
- in_last with in_valid=0 is ignored.
- Reset asserted mid-frame or mid-WAIT: immediate return to the reset state, partial data discarded.
- Counter width = clog2(N); it never wraps past N-1.
- busy = (state==FIRE)|(state==WAIT).

Test Plan:
1. Params W=H=4, C=1; stream beats 0..15 with in_last on beat 15 -> data_valid pulses once, one cycle after beat 15. feature_map[k*8+:8]==k for all k; in_ready=0 from that cycle.
2. After scenario 1, hold result_valid=0 for 20 cycles while driving in_valid=1 -> no beat accepted, feature_map unchanged. Pulse result_valid -> in_ready=1 one cycle later.
3. Assert in_last on beat 9 of 16 -> frame_error one-cycle pulse, no data_valid. Next full 16-beat frame loads correctly from slot 0.
4. 16 beats with in_last=0 on beat 15 -> frame_error pulse, state stays LOAD, counter=0.
5. Random in_valid gaps (~50%) with C=2, W=H=3 -> 18 beats land in channel-major order. data_valid pulses exactly once.
6. Drop reset_n while at beat 7 of a frame and while in WAIT -> outputs return to reset values asynchronously. A subsequent full frame completes normally.
